// File: rtl/udp_tx_arbiter_if.sv
// udp_tx_arbiter_if: bundle of every signal between the UDP transmit arbiter,
// its NUM_SRC packet sources and the downstream UDP/IP layer.
//
// Handshake semantics (source <-> arbiter <-> UDP/IP layer):
//   A source raises src_request[i] with a non-zero src_length[i] and holds
//   both until its packet is finished or it sees src_abort[i]. The arbiter
//   forwards the request downstream as udp_tx_request. udp_tx_enable is the
//   acceptance strobe; it is routed to the granted source in the same cycle
//   so the source can present its first byte. After acceptance, every cycle
//   with udp_tx_active=1 consumes exactly one byte of udp_tx_data (mirrored
//   to the source as src_active). The first cycle with udp_tx_active=0 after
//   at least one byte ends the packet.
//
// Port summary (master = arbiter side, slave = sources/downstream side):
//   src_request/src_length/src_port/src_data  per-source request and payload
//   src_enable/src_active/src_abort           per-source strobes from arbiter
//   udp_tx_enable/udp_tx_active               downstream strobes
//   udp_tx_request/length/data, port_ID       downstream request path
//   grant, busy, len_error                    status
//   dbg_state                                 arbiter FSM state (debug)
interface udp_tx_arbiter_if #(
  parameter int NUM_SRC = 4
);
  localparam int GW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]    src_request;
  logic [NUM_SRC*16-1:0] src_length;
  logic [NUM_SRC*8-1:0]  src_port;
  logic [NUM_SRC*8-1:0]  src_data;
  logic [NUM_SRC-1:0]    src_enable;
  logic [NUM_SRC-1:0]    src_active;
  logic [NUM_SRC-1:0]    src_abort;
  logic                  udp_tx_enable;
  logic                  udp_tx_active;
  logic                  udp_tx_request;
  logic [15:0]           udp_tx_length;
  logic [7:0]            udp_tx_data;
  logic [7:0]            port_ID;
  logic [GW-1:0]         grant;
  logic                  busy;
  logic                  len_error;
  logic [1:0]            dbg_state;

  modport master (
    input  src_request, src_length, src_port, src_data,
    input  udp_tx_enable, udp_tx_active,
    output src_enable, src_active, src_abort,
    output udp_tx_request, udp_tx_length, udp_tx_data, port_ID,
    output grant, busy, len_error, dbg_state
  );

  modport slave (
    output src_request, src_length, src_port, src_data,
    output udp_tx_enable, udp_tx_active,
    input  src_enable, src_active, src_abort,
    input  udp_tx_request, udp_tx_length, udp_tx_data, port_ID,
    input  grant, busy, len_error, dbg_state
  );
endinterface

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: shares the single UDP transmit path between NUM_SRC packet
// sources. One source is granted per packet (PRI_SRC first, otherwise
// round-robin), its length/port are registered and its data is muxed onto
// the path. A forced inter-packet gap and a pre-data watchdog keep a stalled
// source from locking the Ethernet path.
//
// Ports:
//   tx_clock  transmit clock
//   reset     asynchronous, active-high reset
//   bus       udp_tx_arbiter_if.master (sources, downstream and status)
module udp_tx_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int PRI_SRC    = 0,
  parameter int GAP_CYCLES = 12,
  parameter int TIMEOUT    = 50000
) (
  input  logic              tx_clock,
  input  logic              reset,
  udp_tx_arbiter_if.master  bus
);
  localparam int GW  = $clog2(NUM_SRC);
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam int GPW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [GW-1:0]  last_q, last_d;
  logic [15:0]    len_q, len_d;
  logic [15:0]    byte_q, byte_d;
  logic [7:0]     port_q, port_d;
  logic           seen_q, seen_d;
  logic           lerr_q, lerr_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic [GPW-1:0] gap_q, gap_d;

  logic [NUM_SRC-1:0] nz;
  logic [NUM_SRC-1:0] elig;
  logic               win_valid;
  logic [GW-1:0]      win_idx;
  logic               wd_hit;
  logic               abort_fire;

  // A zero-length request is never eligible.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_nz
    assign nz[i] = |bus.src_length[i*16 +: 16];
  end
  assign elig = bus.src_request & nz;

  // Round-robin search from last_q+1. The loop runs from the farthest
  // candidate to the nearest so the nearest eligible one is assigned last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (elig[GW'((int'(last_q) + k) % NUM_SRC)]) begin
        win_valid = 1'b1;
        win_idx   = GW'((int'(last_q) + k) % NUM_SRC);
      end
    end
    if (elig[GW'(PRI_SRC)]) begin
      win_valid = 1'b1;
      win_idx   = GW'(PRI_SRC);
    end
  end

  // Watchdog expiry on the TIMEOUT-th pre-data cycle. Acceptance (enable in
  // REQ, first active byte in XFER) in the same cycle takes precedence.
  assign wd_hit     = (wd_q == WDW'(TIMEOUT - 1));
  assign abort_fire = wd_hit &&
                      (((state_q == REQ) && !bus.udp_tx_enable) ||
                       ((state_q == XFER) && !seen_q && !bus.udp_tx_active));

  // State register
  always_ff @(posedge tx_clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_SRC - 1);
      len_q   <= '0;
      byte_q  <= '0;
      port_q  <= '0;
      seen_q  <= 1'b0;
      lerr_q  <= 1'b0;
      wd_q    <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      len_q   <= len_d;
      byte_q  <= byte_d;
      port_q  <= port_d;
      seen_q  <= seen_d;
      lerr_q  <= lerr_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    len_d   = len_q;
    byte_d  = byte_q;
    port_d  = port_q;
    seen_d  = seen_q;
    lerr_d  = lerr_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          grant_d = win_idx;
          last_d  = win_idx;
          len_d   = bus.src_length[win_idx*16 +: 16];
          port_d  = bus.src_port[win_idx*8 +: 8];
          wd_d    = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.udp_tx_enable) begin
          byte_d  = '0;
          seen_d  = 1'b0;
          wd_d    = '0;
          state_d = XFER;
        end else if (abort_fire) begin
          wd_d    = '0;
          gap_d   = '0;
          state_d = GAP;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      XFER: begin
        if (bus.udp_tx_active) begin
          byte_d = byte_q + 16'd1;
          seen_d = 1'b1;
        end else if (seen_q) begin
          lerr_d  = lerr_q | (byte_q != len_q);
          wd_d    = '0;
          gap_d   = '0;
          state_d = GAP;
        end else if (abort_fire) begin
          wd_d    = '0;
          gap_d   = '0;
          state_d = GAP;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      GAP: begin
        if (gap_q == GPW'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GPW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs. Strobes and data are combinational so the granted source sees
  // enable/active in the same cycle the downstream layer asserts them.
  always_comb begin
    bus.udp_tx_request = (state_q == REQ) || (state_q == XFER);
    bus.src_enable     = '0;
    bus.src_active     = '0;
    bus.src_abort      = '0;
    bus.udp_tx_data    = '0;
    case (state_q)
      REQ: begin
        bus.src_enable[grant_q] = bus.udp_tx_enable;
        bus.udp_tx_data         = bus.src_data[grant_q*8 +: 8];
      end
      XFER: begin
        bus.src_active[grant_q] = bus.udp_tx_active;
        bus.udp_tx_data         = bus.src_data[grant_q*8 +: 8];
      end
      default: ;
    endcase
    bus.src_abort[grant_q] = abort_fire;
    bus.udp_tx_length      = len_q;
    bus.port_ID            = port_q;
    bus.grant              = grant_q;
    bus.busy               = (state_q != IDLE);
    bus.len_error          = lerr_q;
    bus.dbg_state          = state_q;
  end
endmodule

// File: tb/tb_udp_tx_arbiter.sv
module tb_udp_tx_arbiter;
  localparam int NS  = 4;
  localparam int GAP = 12;
  localparam int TO  = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  udp_tx_arbiter_if #(.NUM_SRC(NS)) bus();

  udp_tx_arbiter #(
    .NUM_SRC(NS), .PRI_SRC(0), .GAP_CYCLES(GAP), .TIMEOUT(TO)
  ) dut (
    .tx_clock(clk),
    .reset(rst),
    .bus(bus)
  );

  logic        req_a[NS];
  logic [15:0] len_a[NS];
  logic [7:0]  port_a[NS];
  assign bus.src_request = {req_a[3], req_a[2], req_a[1], req_a[0]};
  assign bus.src_length  = {len_a[3], len_a[2], len_a[1], len_a[0]};
  assign bus.src_port    = {port_a[3], port_a[2], port_a[1], port_a[0]};

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [3:0] req;
    logic [3:0] zl;
    logic       exp_busy;
    logic [1:0] exp_grant;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.udp_tx_enable = 1'b0;
    bus.udp_tx_active = 1'b0;
    bus.src_data = '0;
    req_a = '{default: 1'b0};
    len_a = '{default: 16'd0};
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_src(input logic [1:0] g, input logic r, input logic [15:0] l);
    req_a[g] = r;
    len_a[g] = l;
  endtask

  task automatic apply_mask(input logic [3:0] req, input logic [3:0] zl);
    req_a = '{req[0], req[1], req[2], req[3]};
    len_a = '{zl[0] ? 16'd0 : 16'd100, zl[1] ? 16'd0 : 16'd101,
              zl[2] ? 16'd0 : 16'd102, zl[3] ? 16'd0 : 16'd103};
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_request"}, 32'(bus.udp_tx_request), 32'd0);
    check({tag, "_length"},  32'(bus.udp_tx_length),  32'd0);
    check({tag, "_data"},    32'(bus.udp_tx_data),    32'd0);
    check({tag, "_port"},    32'(bus.port_ID),        32'd0);
    check({tag, "_grant"},   32'(bus.grant),          32'd0);
    check({tag, "_busy"},    32'(bus.busy),           32'd0);
    check({tag, "_enable"},  32'(bus.src_enable),     32'd0);
    check({tag, "_active"},  32'(bus.src_active),     32'd0);
    check({tag, "_abort"},   32'(bus.src_abort),      32'd0);
    check({tag, "_lenerr"},  32'(bus.len_error),      32'd0);
  endtask

  // Starts in a REQ cycle; returns in the first GAP cycle.
  task automatic do_packet(input logic [1:0] g, input int en_delay, input int nact, input logic drop);
    logic [31:0] dv;
    for (int i = 0; i < en_delay; i++) begin
      check("req_wait_request", 32'(bus.udp_tx_request), 32'd1);
      check("req_wait_enable", 32'(bus.src_enable), 32'd0);
      cyc();
    end
    bus.udp_tx_enable = 1'b1;
    #1;
    check("enable_route", 32'(bus.src_enable), 32'd1 << g);
    check("grant", 32'(bus.grant), 32'(g));
    cyc();
    bus.udp_tx_enable = 1'b0;
    for (int b = 0; b < nact; b++) begin
      bus.udp_tx_active = 1'b1;
      bus.src_data = $urandom;
      #1;
      dv = bus.src_data;
      check("xfer_data", 32'(bus.udp_tx_data), 32'(dv[g*8 +: 8]));
      check("xfer_active_route", 32'(bus.src_active), 32'd1 << g);
      check("xfer_request", 32'(bus.udp_tx_request), 32'd1);
      cyc();
    end
    bus.udp_tx_active = 1'b0;
    if (drop) req_a[g] = 1'b0;
    #1;
    check("xfer_exit_request", 32'(bus.udp_tx_request), 32'd1);
    cyc();
  endtask

  task automatic check_gap(input int n);
    for (int i = 0; i < n; i++) begin
      check("gap_busy", 32'(bus.busy), 32'd1);
      check("gap_request", 32'(bus.udp_tx_request), 32'd0);
      check("gap_enable", 32'(bus.src_enable), 32'd0);
      check("gap_active", 32'(bus.src_active), 32'd0);
      check("gap_data", 32'(bus.udp_tx_data), 32'd0);
      cyc();
    end
  endtask

  task automatic check_idle();
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_request", 32'(bus.udp_tx_request), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench time limit");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] e;
    logic [1:0]  g;

    vecs[0] = '{4'b0010, 4'b0000, 1'b1, 2'd1};
    vecs[1] = '{4'b1110, 4'b0000, 1'b1, 2'd1};
    vecs[2] = '{4'b1111, 4'b0000, 1'b1, 2'd0};
    vecs[3] = '{4'b1000, 4'b0000, 1'b1, 2'd3};
    vecs[4] = '{4'b0101, 4'b0001, 1'b1, 2'd2};
    vecs[5] = '{4'b0001, 4'b0001, 1'b0, 2'd0};
    vecs[6] = '{4'b1100, 4'b0000, 1'b1, 2'd2};
    vecs[7] = '{4'b0000, 4'b0000, 1'b0, 2'd0};
    vecs[8] = '{4'b1011, 4'b0001, 1'b1, 2'd1};

    port_a = '{8'h10, 8'h11, 8'h12, 8'h13};
    req_a  = '{default: 1'b0};
    len_a  = '{default: 16'd0};
    bus.udp_tx_enable = 1'b0;
    bus.udp_tx_active = 1'b0;
    bus.src_data = '0;

    // Reset state
    #3;
    check_all_zero("reset");
    do_reset();

    // Table: first arbitration decision out of reset
    for (int v = 0; v < 9; v++) begin
      do_reset();
      apply_mask(vecs[v].req, vecs[v].zl);
      #1;
      check("tbl_busy_pre", 32'(bus.busy), 32'd0);
      cyc();
      check("tbl_busy", 32'(bus.busy), 32'(vecs[v].exp_busy));
      check("tbl_request", 32'(bus.udp_tx_request), 32'(vecs[v].exp_busy));
      check("tbl_grant", 32'(bus.grant), vecs[v].exp_busy ? 32'(vecs[v].exp_grant) : 32'd0);
      check("tbl_length", 32'(bus.udp_tx_length),
            vecs[v].exp_busy ? 32'd100 + 32'(vecs[v].exp_grant) : 32'd0);
      check("tbl_port", 32'(bus.port_ID),
            vecs[v].exp_busy ? 32'h10 + 32'(vecs[v].exp_grant) : 32'd0);
      bus.udp_tx_enable = 1'b1;
      #1;
      check("tbl_enable", 32'(bus.src_enable),
            vecs[v].exp_busy ? (32'd1 << vecs[v].exp_grant) : 32'd0);
      bus.udp_tx_enable = 1'b0;
    end

    // 1: single source 1, 60 bytes, enable after 5 cycles
    do_reset();
    set_src(2'd1, 1'b1, 16'd60);
    #1;
    check("t1_request_latency", 32'(bus.udp_tx_request), 32'd0);
    cyc();
    check("t1_request", 32'(bus.udp_tx_request), 32'd1);
    check("t1_port", 32'(bus.port_ID), 32'h11);
    check("t1_length", 32'(bus.udp_tx_length), 32'd60);
    do_packet(2'd1, 5, 60, 1'b1);
    check("t1_len_error", 32'(bus.len_error), 32'd0);
    check_gap(GAP);
    check_idle();
    cyc();
    check_idle();

    // 2: sources 1,2,3 held; round-robin order 1,2,3,1. Between packets the
    // request is low for the 12 gap cycles plus the 1-cycle arbitration.
    do_reset();
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd1};
    set_src(2'd1, 1'b1, 16'd4);
    set_src(2'd2, 1'b1, 16'd4);
    set_src(2'd3, 1'b1, 16'd4);
    cyc();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = e[1:0];
      check("t2_grant_order", 32'(bus.grant), e);
      do_packet(g, 1, 4, 1'b0);
      check_gap(GAP);
      check_idle();
      cyc();
    end
    check("t2_len_error", 32'(bus.len_error), 32'd0);

    // 3: source 2 arrives during gap, PRI source 0 arrives later but wins
    do_reset();
    set_src(2'd1, 1'b1, 16'd8);
    cyc();
    do_packet(2'd1, 0, 8, 1'b1);
    set_src(2'd2, 1'b1, 16'd6);
    check_gap(5);
    set_src(2'd0, 1'b1, 16'd7);
    check_gap(GAP - 5);
    check_idle();
    cyc();
    check("t3_pri_grant", 32'(bus.grant), 32'd0);
    check("t3_pri_length", 32'(bus.udp_tx_length), 32'd7);
    do_packet(2'd0, 0, 7, 1'b1);
    check_gap(GAP);
    check_idle();
    cyc();
    check("t3_second_grant", 32'(bus.grant), 32'd2);
    check("t3_second_length", 32'(bus.udp_tx_length), 32'd6);
    do_packet(2'd2, 0, 6, 1'b1);
    check_gap(GAP);
    check_idle();

    // 4: source 3, enable never comes -> abort on REQ cycle TO
    do_reset();
    set_src(2'd3, 1'b1, 16'd10);
    cyc();
    for (int c = 1; c < TO; c++) begin
      check("t4_no_abort", 32'(bus.src_abort), 32'd0);
      check("t4_request", 32'(bus.udp_tx_request), 32'd1);
      cyc();
    end
    check("t4_abort_pulse", 32'(bus.src_abort), 32'b1000);
    check("t4_request_at_abort", 32'(bus.udp_tx_request), 32'd1);
    cyc();
    check("t4_abort_cleared", 32'(bus.src_abort), 32'd0);
    set_src(2'd3, 1'b0, 16'd10);
    check_gap(GAP);
    check_idle();

    // 5: length 1028 with 1027 bytes -> sticky len_error
    do_reset();
    set_src(2'd1, 1'b1, 16'd1028);
    cyc();
    do_packet(2'd1, 2, 1027, 1'b1);
    check("t5_len_error_set", 32'(bus.len_error), 32'd1);
    check_gap(GAP);
    check_idle();
    set_src(2'd2, 1'b1, 16'd5);
    cyc();
    check("t5_next_grant", 32'(bus.grant), 32'd2);
    do_packet(2'd2, 0, 5, 1'b1);
    check("t5_len_error_sticky", 32'(bus.len_error), 32'd1);
    check_gap(GAP);

    // 6: async reset at XFER byte 500
    do_reset();
    set_src(2'd0, 1'b1, 16'd800);
    set_src(2'd1, 1'b1, 16'd0);
    cyc();
    check("t6_grant", 32'(bus.grant), 32'd0);
    bus.udp_tx_enable = 1'b1;
    cyc();
    bus.udp_tx_enable = 1'b0;
    for (int b = 0; b < 499; b++) begin
      bus.udp_tx_active = 1'b1;
      bus.src_data = $urandom;
      cyc();
    end
    bus.udp_tx_active = 1'b1;
    bus.src_data = 32'hA5A5A5A5;
    #1;
    check("t6_mid_xfer_request", 32'(bus.udp_tx_request), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("t6_async");
    cyc();
    rst = 1'b0;
    bus.udp_tx_active = 1'b0;
    #1;
    check("t6_idle_after_reset", 32'(bus.busy), 32'd0);
    cyc();
    check("t6_regrant", 32'(bus.grant), 32'd0);
    check("t6_regrant_busy", 32'(bus.busy), 32'd1);
    check("t6_regrant_length", 32'(bus.udp_tx_length), 32'd800);
    do_reset();
    set_src(2'd1, 1'b1, 16'd0);
    for (int c = 0; c < 20; c++) begin
      cyc();
      check("t6_zero_len_busy", 32'(bus.busy), 32'd0);
      check("t6_zero_len_request", 32'(bus.udp_tx_request), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/udp_tx_arbiter.md
Name: udp_tx_arbiter

Overview:
- Shares the single UDP transmit path (udp_tx_request/enable/active/data/length, port_ID) between NUM_SRC packet sources.
- Sources include sdr_send, the DHCP/ARP/ICMP reply engines and the EPCS programming reply.
- Grants one source per packet and muxes its data, length and port onto the path. Forwards the enable/active strobes only to the granted source.
- Enforces an inter-packet gap and a watchdog so that a stalled source cannot lock the Ethernet path.

Parameters:
- NUM_SRC, 4: number of packet sources (2..8).
- PRI_SRC, 0: index of the high-priority source (discovery/response path); it always wins arbitration when requesting.
- GAP_CYCLES, 12: idle tx_clock cycles forced between packets.
- TIMEOUT, 50000: tx_clock cycles allowed in REQ or pre-data XFER before abort.
- GW = clog2(NUM_SRC): local, width of the grant index.

Ports:
- tx_clock  in  1  transmit clock.
- reset  in  1  asynchronous, active-high reset.
- src_request  in  NUM_SRC  per-source packet request; held high until the source's packet is done.
- src_length  in  NUM_SRC*16  per-source UDP payload length in bytes.
- src_port  in  NUM_SRC*8  per-source from-port offset (port_ID).
- src_data  in  NUM_SRC*8  per-source tx byte.
- src_enable  out  NUM_SRC  udp_tx_enable, routed to the granted source.
- src_active  out  NUM_SRC  udp_tx_active, routed to the granted source.
- src_abort  out  NUM_SRC  1-cycle pulse to the granted source on watchdog expiry.
- udp_tx_enable  in  1  downstream: UDP/IP layer accepted the request.
- udp_tx_active  in  1  downstream: byte is being consumed this cycle.
- udp_tx_request  out  1  downstream request.
- udp_tx_length  out  16  registered length of the granted source.
- udp_tx_data  out  8  muxed data.
- port_ID  out  8  registered port of the granted source.
- grant  out  GW  current or last grant index.
- busy  out  1  high in any state other than IDLE.
- len_error  out  1  sticky flag: bytes counted differed from udp_tx_length; cleared only by reset.

Behaviour:
- Reset (async): state=IDLE. All outputs 0. last_grant=NUM_SRC-1, so source 0 wins the first round-robin. Counters 0.
- Eligibility: src_request[i]=1 and src_length[i]!=0. A zero-length request is never granted and causes no other action.
- IDLE:
  - If any source is eligible, pick the winner: PRI_SRC if eligible; otherwise round-robin search from last_grant+1 upward, wrapping.
  - Register grant, udp_tx_length and port_ID, set last_grant, go to REQ.
  - Decision to udp_tx_request high takes 1 cycle.
- REQ:
  - udp_tx_request=1.
  - src_enable[grant] = udp_tx_enable, combinational and same cycle, because sources load their first byte on enable.
  - On udp_tx_enable: go to XFER, clear byte_cnt and active_seen.
- XFER:
  - udp_tx_request stays 1.
  - src_active[grant] = udp_tx_active, combinational.
  - udp_tx_data = src_data[grant], combinational, zero latency. udp_tx_data=0 in IDLE/GAP.
  - byte_cnt increments on each cycle with udp_tx_active=1; active_seen is set.
  - Exit when udp_tx_active=0 and active_seen=1. At exit, set len_error if byte_cnt != udp_tx_length, then go to GAP.
- GAP:
  - udp_tx_request=0 and all src_enable/src_active are 0.
  - Count GAP_CYCLES, then return to IDLE.
  - A granted source still holding src_request is re-arbitrated fairly; because of round-robin it does not win twice in a row if another non-priority source is eligible.
- Watchdog:
  - A counter runs in REQ, and in XFER while active_seen=0.
  - When it reaches TIMEOUT: pulse src_abort[grant] for 1 cycle, drop udp_tx_request, go to GAP.
  - The counter clears on every state change.
- Simultaneous events:
  - udp_tx_enable and watchdog expiry in the same cycle: enable wins, go to XFER.
  - src_request dropping mid-REQ: no effect; the grant holds until the packet completes or times out.
- Mid-packet reset: outputs are forced to 0 immediately. The downstream layer tolerates udp_tx_request dropping.

Test Plan:
1. Single source 1, length 60, enable after 5 cycles, active for 60 cycles.
   -> udp_tx_request high 1 cycle after the request; port_ID/length match source 1; 60 bytes passed byte-exact; request low for 12 cycles; len_error=0.
2. Sources 1, 2 and 3 request together and hold, PRI_SRC idle.
   -> grant order is 1,2,3,1,... with a 12-cycle gap between packets.
3. Sources 0 (PRI) and 2 request, with 2 arriving first while the arbiter is in GAP.
   -> source 0 granted next; source 2 granted after source 0's packet and gap.
4. Source 3 requests and udp_tx_enable is never asserted.
   -> src_abort[3] pulses at cycle 50000 of REQ; request drops; arbiter returns to IDLE after the gap.
5. Source 1 has length 1028 and the downstream delivers 1027 active cycles.
   -> len_error=1 and stays 1 through the next packet.
6. Async reset asserted in the middle of XFER byte 500.
   -> all outputs 0 in the same cycle; after release, source 0 wins if eligible; src_length=0 requesters are never granted.
